conv_output_collector: RTL and testbench

- Receive-side companion to the convolver.
- Captures the convolver's output stream (conv_op qualified by valid_conv, bounded by end_conv) into an on-chip output-feature-map buffer in raster order.
- Drains the buffered map downstream over a valid/ready stream with a last marker.
- Sits directly after the convolver and shares its clk, sclr and ce.

---
 rtl/conv_output_collector.sv | 149 ++++++++++++++
 tb/tb_conv_output_collector.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_output_collector.sv
// conv_output_collector: captures the convolver's output stream into an
// on-chip feature-map buffer in raster order, then drains it downstream over
// a valid/ready stream with a last marker.
// Optional build macro: CONV_COLLECT_RELU_EN -- rectify samples at the write
// port (negative values are stored as zero).
module conv_output_collector #(
  parameter int N       = 16,
  parameter int OUT_DIM = 8,
  parameter int ADDR_W  = 7
) (
  input  logic         clk,
  input  logic         sclr,
  input  logic         ce,
  input  logic         start,
  input  logic [N-1:0] conv_op,
  input  logic         valid_conv,
  input  logic         end_conv,
  output logic [N-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_last,
  output logic         busy,
  output logic         done,
  output logic         short_frame,
  output logic         dropped
);

  localparam int DEPTH = OUT_DIM * OUT_DIM;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] FULL_CNT = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [N-1:0]      mem [0:DEPTH-1];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] end_count;
  logic [ADDR_W-1:0] rd_addr;
  logic [N-1:0]      wr_data;
  logic              wr_en;
  logic              wr_last;
  logic              frame_end;
  logic              handshake;
  logic              load;

  // Write-side qualifiers: a capture needs ce; the final write closes a full frame.
  assign wr_en     = (state == CAPTURE) && ce && valid_conv;
  assign wr_last   = wr_en && (wr_ptr == LAST_IDX);
  // end_conv closes a short frame; a coincident final write wins as a full frame.
  assign frame_end = (state == CAPTURE) && end_conv && !wr_last;
  assign end_count = wr_ptr + {{(ADDR_W-1){1'b0}}, wr_en};

  // Read side: rd_ptr is the index of the presented word. The first read of a
  // drain fetches index 0; each accepted non-final word prefetches the next.
  assign handshake = m_valid && m_ready;
  assign load      = (state == DRAIN) && (!m_valid || (handshake && !m_last));
  assign rd_addr   = m_valid ? (rd_ptr + ONE) : rd_ptr;

  assign busy = (state != IDLE);

`ifdef CONV_COLLECT_RELU_EN
  assign wr_data = conv_op[N-1] ? '0 : conv_op;
`else
  assign wr_data = conv_op;
`endif

  // State register.
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = CAPTURE;
      CAPTURE: begin
        if (wr_last)        state_next = DRAIN;
        else if (frame_end) state_next = (end_count == '0) ? IDLE : DRAIN;
      end
      DRAIN:   if (handshake && m_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Buffer write port (contents deliberately survive reset).
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[IDX_W-1:0]] <= wr_data;
  end

  // Capture bookkeeping: write pointer, frame length, status flags, done pulse.
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      wr_ptr      <= '0;
      count       <= '0;
      short_frame <= 1'b0;
      dropped     <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= (frame_end && (end_count == '0)) || (handshake && m_last);
      if ((state == IDLE) && start) begin
        wr_ptr      <= '0;
        short_frame <= 1'b0;
        dropped     <= 1'b0;
      end
      if (wr_en) wr_ptr <= wr_ptr + ONE;
      if (wr_last) begin
        count <= FULL_CNT;
      end else if (frame_end) begin
        count       <= end_count;
        short_frame <= 1'b1;
      end
      // Any sample offered outside CAPTURE has nowhere to go.
      if (ce && valid_conv && (state != CAPTURE)) dropped <= 1'b1;
    end
  end

  // Drain: registered buffer read feeding the output stream; holds while stalled.
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      rd_ptr  <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      if (state != DRAIN) rd_ptr <= '0;
      else if (load)      rd_ptr <= rd_addr;
      if (load) begin
        m_data  <= mem[rd_addr[IDX_W-1:0]];
        m_valid <= 1'b1;
        m_last  <= (rd_addr == (count - ONE));
      end else if (handshake) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_output_collector.sv
// Scoreboard bench for conv_output_collector: stimulus queues the expected
// drained words; a negedge monitor pops and compares on every handshake.
module tb_conv_output_collector;

  localparam int N     = 16;
  localparam int DEPTH = 64;

  logic         clk = 1'b0;
  logic         sclr;
  logic         ce;
  logic         start;
  logic [N-1:0] conv_op;
  logic         valid_conv;
  logic         end_conv;
  logic [N-1:0] m_data;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;
  logic         busy;
  logic         done;
  logic         short_frame;
  logic         dropped;

  conv_output_collector #(.N(N), .OUT_DIM(8), .ADDR_W(7)) dut (
    .clk(clk), .sclr(sclr), .ce(ce), .start(start), .conv_op(conv_op),
    .valid_conv(valid_conv), .end_conv(end_conv), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .busy(busy),
    .done(done), .short_frame(short_frame), .dropped(dropped)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] d;
    logic         l;
  } exp_t;

  exp_t         exp_q[$];
  logic [N-1:0] stim [0:79];
  int           n_checks = 0;
  int           n_fail = 0;
  int           done_cnt = 0;
  int           hs_cnt = 0;
  int           ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model of the write port transform.
  function automatic logic [N-1:0] model(input logic [N-1:0] x);
`ifdef CONV_COLLECT_RELU_EN
    return ($signed(x) < 0) ? '0 : x;
`else
    return x;
`endif
  endfunction

  // Downstream ready generator: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
  initial begin
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int pidx = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       begin m_ready = pat[pidx]; pidx = (pidx + 1) % 4; end
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: scoreboard pop on handshake, stall stability, done pulse count.
  initial begin
    bit           stall_prev = 1'b0;
    logic [N-1:0] prev_data = '0;
    logic         prev_last = 1'b0;
    exp_t         e;
    forever begin
      @(negedge clk);
      if (sclr) begin
        stall_prev = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (stall_prev) begin
          check("stall_valid", m_valid, 1);
          check("stall_data", m_data, prev_data);
          check("stall_last", m_last, prev_last);
        end
        if (m_valid && m_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_word", m_data, 32'hDEAD_BEEF);
          end else begin
            e = exp_q.pop_front();
            check("drain_data", m_data, e.d);
            check("drain_last", m_last, e.l);
          end
        end
        stall_prev = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
      end
    end
  end

  // Arm and feed one frame of n samples from stim[], with random ce/valid gaps.
  task automatic capture(input string tag, input int n, input bit end_on_last);
    int cap;
    cap = (n < DEPTH) ? n : DEPTH;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_arm"}, busy, 1);
    check({tag, "_drop_clr"}, dropped, 0);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          ce = 1'b0; valid_conv = 1'b1; conv_op = N'($urandom);
        end else begin
          ce = 1'b1; valid_conv = 1'b0;
        end
        @(posedge clk); #1;
      end
      ce = 1'b1; valid_conv = 1'b1; conv_op = stim[i];
      end_conv = end_on_last && (i == n - 1);
      if (i < DEPTH) exp_q.push_back('{d: model(stim[i]), l: (i == cap - 1)});
      @(posedge clk); #1;
    end
    valid_conv = 1'b0; end_conv = 1'b0;
    // Close a short frame on its own cycle with ce low: end_conv must still count.
    if (!end_on_last && n < DEPTH) begin
      ce = 1'b0; end_conv = 1'b1;
      @(posedge clk); #1;
      end_conv = 1'b0; ce = 1'b1;
    end
  endtask

  task automatic run_frame(input string tag, input int n, input bit end_on_last, input int mode);
    int d0;
    int t;
    ready_mode = mode;
    d0 = done_cnt;
    capture(tag, n, end_on_last);
    t = 0;
    while (done_cnt == d0 && t < 4000) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check({tag, "_short"}, short_frame, (n < DEPTH) ? 1 : 0);
    check({tag, "_dropped"}, dropped, (n > DEPTH) ? 1 : 0);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_valid_end"}, m_valid, 0);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    $display("frame %s: n=%0d end_on_last=%0d ready_mode=%0d", tag, n, end_on_last, mode);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int h0;
    int t;
    sclr = 1'b1; ce = 1'b1; start = 1'b0; conv_op = '0;
    valid_conv = 1'b0; end_conv = 1'b0;
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_short", short_frame, 0);
    check("rst_dropped", dropped, 0);
    repeat (3) @(posedge clk);
    #1 sclr = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 80; i++) stim[i] = N'(i);
    run_frame("full_ramp", 64, 1'b0, 0);

    for (int i = 0; i < 80; i++) stim[i] = N'($urandom);
    run_frame("backpressure", 64, 1'b0, 1);

    for (int i = 0; i < 80; i++) stim[i] = N'($urandom);
    run_frame("short10", 10, 1'b1, 2);

    for (int i = 0; i < 80; i++) stim[i] = N'($urandom);
    run_frame("short5_ce_low_end", 5, 1'b0, 2);

    run_frame("empty", 0, 1'b0, 0);

    for (int i = 0; i < 80; i++) stim[i] = N'($urandom);
    run_frame("full_with_end", 64, 1'b1, 2);

    // Sample offered while idle is dropped and never shows up downstream.
    ce = 1'b1; valid_conv = 1'b1; conv_op = 16'h5A5A;
    @(posedge clk); #1;
    valid_conv = 1'b0;
    @(posedge clk); #1;
    check("idle_drop_flag", dropped, 1);
    check("idle_drop_valid", m_valid, 0);
    check("idle_drop_busy", busy, 0);
    $display("idle drop: dropped=%0d", dropped);

    for (int i = 0; i < 80; i++) stim[i] = N'($urandom);
    run_frame("overflow65", 65, 1'b0, 0);

    // Reset in the middle of a drain abandons the frame without done.
    for (int i = 0; i < 80; i++) stim[i] = N'($urandom);
    ready_mode = 0;
    d0 = done_cnt;
    h0 = hs_cnt;
    capture("reset_mid", 64, 1'b0);
    t = 0;
    while (hs_cnt < h0 + 20 && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    check("reset_mid_reached20", (hs_cnt >= h0 + 20) ? 1 : 0, 1);
    sclr = 1'b1;
    #1;
    check("reset_mid_valid", m_valid, 0);
    check("reset_mid_busy", busy, 0);
    check("reset_mid_last", m_last, 0);
    exp_q.delete();
    @(posedge clk); #1;
    sclr = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_mid_no_done", done_cnt - d0, 0);
    check("reset_mid_idle_valid", m_valid, 0);
    $display("reset mid-drain after %0d handshakes", hs_cnt - h0);

    for (int i = 0; i < 80; i++) stim[i] = N'($urandom);
    run_frame("after_reset", 64, 1'b0, 2);

    stim[0] = 16'hF000;
    stim[1] = 16'h0123;
    run_frame("relu_pair", 2, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
